// File: rtl/outlier_eraser.sv
`default_nettype none
// outlier_eraser: drains the outlier FIFO and zeroes each outlier's N-bit lane in the x/y/z BRAMs by read-modify-write.
// Optional macro OUTLIER_MERGE_EN: folds FIFO entries hitting the word under RMW into a single write.
module outlier_eraser #(
  parameter int N        = 16,
  parameter int BUS_SIZE = 32,
  parameter int ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [N-1:0]        point_cloud_size,
  input  logic                fifo_empty,
  input  logic [N-1:0]        fifo_data,
  output logic                read_fifo,
  output logic                bram_en,
  output logic                bram_we,
  output logic [ADDR_W-1:0]   bram_addr,
  input  logic [BUS_SIZE-1:0] bram_rdata_x,
  input  logic [BUS_SIZE-1:0] bram_rdata_y,
  input  logic [BUS_SIZE-1:0] bram_rdata_z,
  output logic [BUS_SIZE-1:0] bram_wdata_x,
  output logic [BUS_SIZE-1:0] bram_wdata_y,
  output logic [BUS_SIZE-1:0] bram_wdata_z,
  output logic                busy,
  output logic                done,
  output logic [N-1:0]        removed_count,
  output logic [N-1:0]        dropped_count
);

  localparam int LANES  = BUS_SIZE / N;
  localparam int SHIFT  = $clog2(LANES);
  localparam int LANE_W = (LANES > 1) ? SHIFT : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_RD    = 3'd2,
    S_WT    = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0]   word_addr;
  logic [LANES-1:0]    mask;
  logic [N-1:0]        folded;
  logic                rd_d;
  logic [BUS_SIZE-1:0] cap_x, cap_y, cap_z;
  logic [BUS_SIZE-1:0] keep;

  logic [N-1:0]        head_word;
  logic [LANE_W-1:0]   head_lane;
  logic [LANES-1:0]    head_mask;
  logic                head_valid;
  logic                merge_hit;
  logic [N:0]          rem_sum;

  // Index 0 is the FIFO's empty-slot sentinel, never a real outlier.
  assign head_word  = fifo_data >> SHIFT;
  assign head_lane  = LANE_W'(fifo_data & N'(LANES - 1));
  assign head_mask  = LANES'(1) << head_lane;
  assign head_valid = (fifo_data != '0) && (fifo_data < point_cloud_size);
  assign rem_sum    = {1'b0, removed_count} + {1'b0, folded};

`ifdef OUTLIER_MERGE_EN
  logic [N-1:0] cur_word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_word <= '0;
    end else if (state == S_DRAIN && !fifo_empty && head_valid) begin
      cur_word <= head_word;
    end
  end

  assign merge_hit = (state == S_WT) && !fifo_empty && head_valid && (head_word == cur_word);
`else
  assign merge_hit = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    read_fifo = 1'b0;
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    busy      = (state != S_IDLE) && (state != S_DONE);
    done      = (state == S_DONE);
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          state_nx = S_DONE;
        end else begin
          read_fifo = 1'b1;
          if (head_valid) state_nx = S_RD;
        end
      end
      S_RD: begin
        bram_en  = 1'b1;
        state_nx = S_WT;
      end
      S_WT: begin
        if (merge_hit) read_fifo = 1'b1;
        else           state_nx  = S_WR;
      end
      S_WR: begin
        bram_en  = 1'b1;
        bram_we  = 1'b1;
        state_nx = S_DRAIN;
      end
      S_DONE: begin
        if (!start) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      word_addr     <= '0;
      mask          <= '0;
      folded        <= '0;
      rd_d          <= 1'b0;
      cap_x         <= '0;
      cap_y         <= '0;
      cap_z         <= '0;
      removed_count <= '0;
      dropped_count <= '0;
    end else begin
      state <= state_nx;
      rd_d  <= (state == S_RD);
      case (state)
        S_IDLE: begin
          if (start) begin
            removed_count <= '0;
            dropped_count <= '0;
          end
        end
        S_DRAIN: begin
          if (!fifo_empty) begin
            if (head_valid) begin
              word_addr <= BASE_ADDR + ADDR_W'(head_word);
              mask      <= head_mask;
              folded    <= N'(1);
            end else if (dropped_count != '1) begin
              dropped_count <= dropped_count + N'(1);
            end
          end
        end
        S_WT: begin
          // Read data is only valid on the first WT cycle; merge cycles leave the port idle.
          if (rd_d) begin
            cap_x <= bram_rdata_x;
            cap_y <= bram_rdata_y;
            cap_z <= bram_rdata_z;
          end
          if (merge_hit) begin
            mask <= mask | head_mask;
            if (folded != '1) folded <= folded + N'(1);
          end
        end
        S_WR: begin
          removed_count <= rem_sum[N] ? '1 : rem_sum[N-1:0];
          mask          <= '0;
          folded        <= '0;
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign keep[k*N +: N] = {N{~mask[k]}};
  end

  assign bram_addr    = word_addr;
  assign bram_wdata_x = cap_x & keep;
  assign bram_wdata_y = cap_y & keep;
  assign bram_wdata_z = cap_z & keep;

endmodule

`default_nettype wire

// File: tb/tb_outlier_eraser.sv
`default_nettype none
// tb_outlier_eraser: scoreboard bench; expected BRAM writes are queued when the FIFO is loaded.
module tb_outlier_eraser;

  localparam int N     = 16;
  localparam int BUS   = 32;
  localparam int AW    = 32;
  localparam int LANES = BUS / N;
  localparam int DEPTH = 128;
  localparam int FDEP  = 4096;
  localparam int LIMIT = 20000;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [BUS-1:0] x;
    logic [BUS-1:0] y;
    logic [BUS-1:0] z;
  } wr_t;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [N-1:0]   pcs;
  logic           fifo_empty;
  logic [N-1:0]   fifo_data;
  logic           read_fifo;
  logic           bram_en, bram_we;
  logic [AW-1:0]  bram_addr;
  logic [BUS-1:0] rdata_x, rdata_y, rdata_z;
  logic [BUS-1:0] wdata_x, wdata_y, wdata_z;
  logic           busy, done;
  logic [N-1:0]   removed_count, dropped_count;

  logic [BUS-1:0] mem_x [DEPTH];
  logic [BUS-1:0] mem_y [DEPTH];
  logic [BUS-1:0] mem_z [DEPTH];
  logic [BUS-1:0] ref_x [DEPTH];
  logic [BUS-1:0] ref_y [DEPTH];
  logic [BUS-1:0] ref_z [DEPTH];

  logic           pl_en;
  logic [6:0]     pl_addr;
  logic [BUS-1:0] pl_x, pl_y, pl_z;

  logic [N-1:0]   fifo_mem [FDEP];
  int             wr_ptr = 0;
  int             rd_ptr = 0;

  wr_t            sb [$];
  logic [N-1:0]   batch [$];
  int             exp_rem, exp_drop;
  int             n_cmp = 0, n_err = 0;
  int             pop_empty_cnt = 0, unexp_wr_cnt = 0;

  always #5 clock = ~clock;

  outlier_eraser #(.N(N), .BUS_SIZE(BUS), .ADDR_W(AW), .BASE_ADDR('0)) dut (
    .clock(clock), .reset(reset), .start(start), .point_cloud_size(pcs),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .read_fifo(read_fifo),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_rdata_x(rdata_x), .bram_rdata_y(rdata_y), .bram_rdata_z(rdata_z),
    .bram_wdata_x(wdata_x), .bram_wdata_y(wdata_y), .bram_wdata_z(wdata_z),
    .busy(busy), .done(done), .removed_count(removed_count), .dropped_count(dropped_count)
  );

  // First-word-fall-through FIFO model.
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = fifo_mem[rd_ptr[11:0]];

  always @(posedge clock) begin
    if (read_fifo && !fifo_empty) rd_ptr <= rd_ptr + 1;
  end

  // Single-port BRAM model with one-cycle read latency, plus a bench preload port.
  always @(posedge clock) begin
    if (pl_en) begin
      mem_x[pl_addr] <= pl_x;
      mem_y[pl_addr] <= pl_y;
      mem_z[pl_addr] <= pl_z;
    end else if (bram_en) begin
      if (bram_we) begin
        mem_x[bram_addr[6:0]] <= wdata_x;
        mem_y[bram_addr[6:0]] <= wdata_y;
        mem_z[bram_addr[6:0]] <= wdata_z;
      end
      rdata_x <= mem_x[bram_addr[6:0]];
      rdata_y <= mem_y[bram_addr[6:0]];
      rdata_z <= mem_z[bram_addr[6:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and sample away from the edge; every DUT write is scored here.
  task automatic tick();
    wr_t e;
    @(posedge clock);
    #1;
    if (read_fifo && fifo_empty) pop_empty_cnt++;
    if (bram_en && bram_we) begin
      if (sb.size() == 0) begin
        unexp_wr_cnt++;
      end else begin
        e = sb.pop_front();
        check("wr_addr", bram_addr, e.addr);
        check("wr_x", wdata_x, e.x);
        check("wr_y", wdata_y, e.y);
        check("wr_z", wdata_z, e.z);
      end
    end
  endtask

  task automatic preload(input int w, input logic [BUS-1:0] x, input logic [BUS-1:0] y,
                         input logic [BUS-1:0] z);
    pl_en = 1'b1; pl_addr = 7'(w); pl_x = x; pl_y = y; pl_z = z;
    ref_x[w] = x; ref_y[w] = y; ref_z[w] = z;
    tick();
    pl_en = 1'b0;
  endtask

  function automatic logic [BUS-1:0] keep_bits(input logic [LANES-1:0] m);
    logic [BUS-1:0] k;
    k = '1;
    for (int l = 0; l < LANES; l++) if (m[l]) k[l*N +: N] = '0;
    return k;
  endfunction

  function automatic bit is_valid(input logic [N-1:0] idx);
    return (idx != 0) && (idx < pcs);
  endfunction

  task automatic fifo_push(input logic [N-1:0] v);
    fifo_mem[wr_ptr % FDEP] = v;
    wr_ptr++;
  endtask

  // Push the batch into the FIFO and queue the writes the DUT should make.
  task automatic load_batch();
    int             i;
    int             w;
    logic [N-1:0]   idx;
    logic [LANES-1:0] m;
    wr_t            e;
    exp_rem = 0; exp_drop = 0; i = 0;
    while (i < batch.size()) begin
      idx = batch[i]; fifo_push(idx); i++;
      if (!is_valid(idx)) begin
        exp_drop++;
        continue;
      end
      w = int'(idx) / LANES;
      m = '0; m[idx % LANES] = 1'b1;
      exp_rem++;
`ifdef OUTLIER_MERGE_EN
      while (i < batch.size() && is_valid(batch[i]) && (int'(batch[i]) / LANES) == w) begin
        fifo_push(batch[i]); m[batch[i] % LANES] = 1'b1; exp_rem++; i++;
      end
`endif
      ref_x[w] = ref_x[w] & keep_bits(m);
      ref_y[w] = ref_y[w] & keep_bits(m);
      ref_z[w] = ref_z[w] & keep_bits(m);
      e.addr = AW'(w); e.x = ref_x[w]; e.y = ref_y[w]; e.z = ref_z[w];
      sb.push_back(e);
    end
  endtask

  task automatic run_drain(input string tag, input int exp_cyc);
    int cyc;
    start = 1'b1; cyc = 0;
    while (!done && cyc < LIMIT) begin
      tick();
      cyc++;
    end
    check({tag, "_done"}, done, 1);
    if (exp_cyc >= 0) check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_removed"}, removed_count, exp_rem);
    check({tag, "_dropped"}, dropped_count, exp_drop);
    check({tag, "_sb_drained"}, sb.size(), 0);
    start = 1'b0;
    tick();
    check({tag, "_done_clr"}, done, 0);
  endtask

  initial begin
    int p0, mism;
    reset = 1'b1; start = 1'b0; pcs = 16'd16; pl_en = 1'b0;
    pl_addr = '0; pl_x = '0; pl_y = '0; pl_z = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_x[i] = '0; ref_y[i] = '0; ref_z[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) preload(i, '0, '0, '0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en", bram_en, 0);
    check("rst_pop", read_fifo, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_cnt", {removed_count, dropped_count}, 0);
    reset = 1'b0;
    tick();

    // Single outlier: index 5 is word 2, lane 1.
    preload(2, 32'hAAAA_BBBB, 32'h1111_2222, 32'hCCCC_DDDD);
    batch = {16'd5};
    load_batch();
    run_drain("single", 6);
    check("single_x2", mem_x[2], 32'h0000_BBBB);
    check("single_y2", mem_y[2], 32'h0000_2222);
    check("single_z2", mem_z[2], 32'h0000_DDDD);

    // Sentinel and out-of-range entries are dropped without touching the BRAM.
    pcs = 16'd17096;
    batch = {16'd0, 16'd17100};
    load_batch();
    run_drain("drop", 4);

    // Both lanes of one word.
    pcs = 16'd16;
    preload(2, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
    batch = {16'd4, 16'd5};
    load_batch();
`ifdef OUTLIER_MERGE_EN
    run_drain("pair", 7);
`else
    run_drain("pair", 10);
`endif
    check("pair_x2", mem_x[2], 32'h0);
    check("pair_z2", mem_z[2], 32'h0);

    // Empty FIFO at start.
    p0 = rd_ptr;
    batch.delete();
    load_batch();
    run_drain("empty", 2);
    check("empty_pops", rd_ptr - p0, 0);

    // Reset while waiting on read data for index 7.
    preload(3, 32'h5555_6666, 32'h7777_8888, 32'h9999_AAAA);
    fifo_push(16'd7);
    start = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_we", bram_we, 0);
    check("abort_en", bram_en, 0);
    check("abort_wdata", wdata_x, 0);
    start = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("abort_x3", mem_x[3], 32'h5555_6666);
    batch = {16'd7};
    load_batch();
    run_drain("restart", 6);
    check("restart_x3", mem_x[3], 32'h0000_6666);

    // Random valid indices against the reference image.
    pcs = 16'd200;
    for (int w = 0; w < 100; w++)
      preload(w, $urandom | 32'h0001_0001, $urandom | 32'h0001_0001, $urandom | 32'h0001_0001);
    batch.delete();
    for (int i = 0; i < 1000; i++) batch.push_back(N'($urandom_range(1, 199)));
    load_batch();
    run_drain("rand", -1);
    mism = 0;
    for (int w = 0; w < DEPTH; w++)
      if (mem_x[w] !== ref_x[w] || mem_y[w] !== ref_y[w] || mem_z[w] !== ref_z[w]) mism++;
    check("rand_image", mism, 0);

    check("pop_while_empty", pop_empty_cnt, 0);
    check("unexpected_writes", unexp_wr_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
